timer16: RTL and testbench

TIMER16 -- requirements
Module: timer16

---
 rtl/timer16.sv | 124 ++++++++++++
 tb/tb_timer16.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer16.sv
// 16-bit down-counting timer with a programmable prescaler, optional auto-reload
// and a level interrupt, controlled through a small synchronous CSR port.
module timer16 (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] csr_a,
    input  logic        csr_we,
    input  logic [15:0] csr_di,
    output logic [15:0] csr_do,
    output logic        irq
);
    localparam logic [2:0] A_CTRL     = 3'd0;
    localparam logic [2:0] A_PRESCALE = 3'd1;
    localparam logic [2:0] A_RELOAD   = 3'd2;
    localparam logic [2:0] A_COUNT    = 3'd3;
    localparam logic [2:0] A_STATUS   = 3'd4;

    logic        en_q, en_d;
    logic        auto_q, auto_d;
    logic        irq_en_q, irq_en_d;
    logic        expired_q, expired_d;
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] count_q, count_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] csr_do_q, csr_do_d;

    logic [2:0]  sel;
    logic        wr_ctrl, wr_prescale, wr_reload, wr_count, wr_status;
    logic        tick, expire;

    always_comb begin
        sel         = csr_a[2:0];
        wr_ctrl     = csr_we && (sel == A_CTRL);
        wr_prescale = csr_we && (sel == A_PRESCALE);
        wr_reload   = csr_we && (sel == A_RELOAD);
        wr_count    = csr_we && (sel == A_COUNT);
        wr_status   = csr_we && (sel == A_STATUS);
        tick        = en_q && (pc_q == prescale_q);
        expire      = tick && (count_q == 16'd0);
    end

    // A CTRL write always wins over the one-shot disable on expiry.
    always_comb begin
        en_d     = en_q;
        auto_d   = auto_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            en_d     = csr_di[0];
            auto_d   = csr_di[1];
            irq_en_d = csr_di[2];
        end else if (expire && !auto_q) begin
            en_d = 1'b0;
        end
    end

    always_comb begin
        prescale_d = wr_prescale ? csr_di : prescale_q;
        reload_d   = wr_reload ? csr_di : reload_q;

        count_d = count_q;
        if (wr_count) begin
            count_d = csr_di;
        end else if (tick) begin
            if (count_q != 16'd0) begin
                count_d = count_q - 16'd1;
            end else if (auto_q) begin
                count_d = reload_q;
            end
        end

        expired_d = expired_q;
        if (expire) begin
            expired_d = 1'b1;
        end else if (wr_status && csr_di[0]) begin
            expired_d = 1'b0;
        end

        // pc restarts from 0 on enable, on each tick and on a PRESCALE write.
        pc_d = 16'd0;
        if (en_q && en_d && !tick && !wr_prescale) begin
            pc_d = pc_q + 16'd1;
        end
    end

    always_comb begin
        case (sel)
            A_CTRL:     csr_do_d = {13'd0, irq_en_q, auto_q, en_q};
            A_PRESCALE: csr_do_d = prescale_q;
            A_RELOAD:   csr_do_d = reload_q;
            A_COUNT:    csr_do_d = count_q;
            A_STATUS:   csr_do_d = {15'd0, expired_q};
            default:    csr_do_d = 16'd0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            en_q       <= 1'b0;
            auto_q     <= 1'b0;
            irq_en_q   <= 1'b0;
            expired_q  <= 1'b0;
            prescale_q <= 16'd0;
            reload_q   <= 16'd0;
            count_q    <= 16'd0;
            pc_q       <= 16'd0;
            csr_do_q   <= 16'd0;
        end else begin
            en_q       <= en_d;
            auto_q     <= auto_d;
            irq_en_q   <= irq_en_d;
            expired_q  <= expired_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pc_q       <= pc_d;
            csr_do_q   <= csr_do_d;
        end
    end

    assign csr_do = csr_do_q;
    assign irq    = expired_q & irq_en_q;

endmodule

// File: tb/tb_timer16.sv
// Directed bench for timer16: an edge-level reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_timer16;
    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [15:0] csr_a   = 16'd0;
    logic        csr_we  = 1'b0;
    logic [15:0] csr_di  = 16'd0;
    logic [15:0] csr_do;
    logic        irq;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_en = 1'b0;

    timer16 dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .csr_a   (csr_a),
        .csr_we  (csr_we),
        .csr_di  (csr_di),
        .csr_do  (csr_do),
        .irq     (irq)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model: register contents plus the absolute edge number of the next tick.
    int          m_edge      = 0;
    int          m_next_tick = 0;
    int          m_pre       = 0;
    int          m_rel       = 0;
    int          m_cnt       = 0;
    bit          m_en        = 1'b0;
    bit          m_auto      = 1'b0;
    bit          m_ie        = 1'b0;
    bit          m_exp       = 1'b0;
    logic [15:0] m_do        = 16'd0;

    function automatic logic [15:0] m_read(input logic [2:0] sel);
        case (sel)
            3'd0:    return {13'd0, m_ie, m_auto, m_en};
            3'd1:    return m_pre[15:0];
            3'd2:    return m_rel[15:0];
            3'd3:    return m_cnt[15:0];
            3'd4:    return {15'd0, m_exp};
            default: return 16'd0;
        endcase
    endfunction

    task automatic model_edge(input logic rst, input logic [15:0] a, input logic we,
                              input logic [15:0] di);
        logic [2:0] sel;
        bit tick, expire, pre_wr;
        bit n_en, n_auto, n_ie, n_exp;
        int n_pre, n_rel, n_cnt, e;
        e      = m_edge + 1;
        m_edge = e;
        if (rst) begin
            m_pre = 0; m_rel = 0; m_cnt = 0;
            m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_exp = 1'b0;
            m_do = 16'd0;
            return;
        end
        sel    = a[2:0];
        m_do   = m_read(sel);
        tick   = m_en && (e == m_next_tick);
        expire = tick && (m_cnt == 0);
        pre_wr = we && (sel == 3'd1);

        n_en = m_en; n_auto = m_auto; n_ie = m_ie;
        if (we && sel == 3'd0) begin
            n_en = di[0]; n_auto = di[1]; n_ie = di[2];
        end else if (expire && !m_auto) begin
            n_en = 1'b0;
        end
        n_pre = pre_wr ? int'(di) : m_pre;
        n_rel = (we && sel == 3'd2) ? int'(di) : m_rel;
        n_cnt = m_cnt;
        if (we && sel == 3'd3) n_cnt = int'(di);
        else if (tick) n_cnt = (m_cnt > 0) ? m_cnt - 1 : (m_auto ? m_rel : 0);
        if (expire) n_exp = 1'b1;
        else if (we && sel == 3'd4 && di[0]) n_exp = 1'b0;
        else n_exp = m_exp;

        // Next tick lands PRESCALE+1 edges after enable, a tick, or a PRESCALE write.
        if (n_en && (!m_en || tick || pre_wr)) m_next_tick = e + n_pre + 1;

        m_en = n_en; m_auto = n_auto; m_ie = n_ie;
        m_pre = n_pre; m_rel = n_rel; m_cnt = n_cnt; m_exp = n_exp;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("csr_do_model", csr_do, m_do);
            check("irq_model", {15'd0, irq}, {15'd0, m_exp & m_ie});
        end
    end

    task automatic step(input logic rst, input logic [15:0] a, input logic we,
                        input logic [15:0] di);
        sys_rst = rst;
        csr_a   = a;
        csr_we  = we;
        csr_di  = di;
        @(posedge sys_clk);
        model_edge(rst, a, we, di);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        csr_a   = 16'd0;
        csr_we  = 1'b0;
        csr_di  = 16'd0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] di);
        step(1'b0, a, 1'b1, di);
    endtask

    task automatic rd(input logic [15:0] a);
        step(1'b0, a, 1'b0, 16'd0);
    endtask

    // Advance until the coming edge is an expiry edge; found=0 if it never arrives.
    task automatic run_to_expiry(input logic [15:0] a, output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (m_en && (m_edge + 1 == m_next_tick) && (m_cnt == 0)) begin
                found = 1'b1;
                break;
            end
            rd(a);
        end
    endtask

    logic [15:0] seq_exp [0:13] = '{16'd2, 16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2,
                                    16'd2, 16'd1, 16'd1, 16'd0, 16'd0, 16'd2, 16'd2};
    logic [15:0] rst_exp [0:4]  = '{16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        step(1'b1, 16'd0, 1'b0, 16'd0);
        chk_en = 1'b1;
        step(1'b1, 16'd0, 1'b0, 16'd0);
        check("reset_do", csr_do, 16'h0000);
        check("reset_irq", {15'd0, irq}, 16'd0);

        // Read latency, address decode, reserved space, CTRL upper bits.
        wr(16'd2, 16'h1234);
        rd(16'd2);
        check("rd_reload", csr_do, 16'h1234);
        rd(16'd5);
        check("rd_reserved", csr_do, 16'h0000);
        rd(16'hFFFA);
        check("rd_upper_ignored", csr_do, 16'h1234);
        wr(16'd6, 16'hFFFF);
        rd(16'd6);
        check("rd_reserved_wr", csr_do, 16'h0000);
        wr(16'd0, 16'hFFFC);
        rd(16'd0);
        check("rd_ctrl_mask", csr_do, 16'h0004);

        // One-shot.
        wr(16'd1, 16'd0);
        wr(16'd3, 16'd3);
        wr(16'd0, 16'h0005);
        rd(16'd4); rd(16'd4); rd(16'd4);
        check("oneshot_irq_early", {15'd0, irq}, 16'd0);
        rd(16'd4);
        check("oneshot_irq", {15'd0, irq}, 16'd1);
        rd(16'd0);
        check("oneshot_ctrl", csr_do, 16'h0004);
        rd(16'd3);
        check("oneshot_count", csr_do, 16'h0000);
        rd(16'd4);
        check("oneshot_status", csr_do, 16'h0001);
        wr(16'd4, 16'h0001);
        check("oneshot_clr_irq", {15'd0, irq}, 16'd0);

        // Auto-reload with prescale 1.
        wr(16'd1, 16'd1);
        wr(16'd2, 16'd2);
        wr(16'd3, 16'd2);
        wr(16'd0, 16'h0003);
        for (int i = 0; i < 14; i++) begin
            rd(16'd3);
            check($sformatf("auto_count[%0d]", i), csr_do, seq_exp[i]);
        end
        rd(16'd4);
        check("auto_status", csr_do, 16'h0001);

        // W1C racing an expiry: set wins, a later W1C clears.
        wr(16'd0, 16'h0007);
        wr(16'd4, 16'h0001);
        run_to_expiry(16'd3, found);
        check("w1c_sync", {15'd0, found}, 16'd1);
        wr(16'd4, 16'h0001);
        rd(16'd4);
        check("w1c_race_status", csr_do, 16'h0001);
        check("w1c_race_irq", {15'd0, irq}, 16'd1);
        wr(16'd4, 16'h0001);
        check("w1c_clr_irq", {15'd0, irq}, 16'd0);
        rd(16'd4);
        check("w1c_clr_status", csr_do, 16'h0000);

        // CTRL write on a one-shot expiry edge keeps EN; EXPIRED still set.
        wr(16'd0, 16'h0000);
        wr(16'd1, 16'd0);
        wr(16'd3, 16'd1);
        wr(16'd4, 16'h0001);
        wr(16'd0, 16'h0005);
        run_to_expiry(16'd0, found);
        check("ctrl_race_sync", {15'd0, found}, 16'd1);
        wr(16'd0, 16'h0001);
        rd(16'd0);
        check("ctrl_race_ctrl", csr_do, 16'h0001);
        rd(16'd4);
        check("ctrl_race_status", csr_do, 16'h0001);
        rd(16'd0);
        check("ctrl_race_ctrl_off", csr_do, 16'h0000);
        check("ctrl_race_irq", {15'd0, irq}, 16'd0);

        // COUNT write on a tick edge: written value wins.
        wr(16'd0, 16'h0003);
        wr(16'd3, 16'd9);
        rd(16'd3);
        check("count_race", csr_do, 16'd9);
        rd(16'd3);
        check("count_race_next", csr_do, 16'd8);

        // Repeated PRESCALE writes hold off every tick.
        wr(16'd0, 16'h0000);
        wr(16'd1, 16'd3);
        wr(16'd3, 16'd7);
        wr(16'd0, 16'h0001);
        for (int i = 0; i < 6; i++) begin
            wr(16'd1, 16'd3);
            rd(16'd3);
        end
        check("prescale_hold", csr_do, 16'd7);

        // Reset mid-count, overriding a simultaneous write.
        wr(16'd0, 16'h0000);
        wr(16'd4, 16'h0001);
        wr(16'd1, 16'd0);
        wr(16'd3, 16'h0010);
        wr(16'd0, 16'h0005);
        for (int i = 0; i < 5; i++) rd(16'd3);
        step(1'b1, 16'd3, 1'b1, 16'h00FF);
        check("rst_mid_do", csr_do, 16'h0000);
        check("rst_mid_irq", {15'd0, irq}, 16'd0);
        wr(16'd2, 16'hBEEF);
        check("rst_first_wr_rd", csr_do, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            rd(16'(i));
            check($sformatf("rst_reg[%0d]", i), csr_do, rst_exp[i]);
        end
        for (int i = 0; i < 30; i++) rd(16'd4);
        check("rst_no_expiry", csr_do, 16'h0000);
        check("rst_no_irq", {15'd0, irq}, 16'd0);

        // 100 unselected idle cycles while auto-reloading.
        wr(16'd1, 16'd2);
        wr(16'd2, 16'd3);
        wr(16'd3, 16'd5);
        wr(16'd0, 16'h0003);
        for (int i = 0; i < 100; i++) rd(16'd0);
        rd(16'd3);
        check("idle_count", csr_do, 16'd0);
        rd(16'd0);
        check("idle_ctrl", csr_do, 16'h0003);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
